lcd_16x2_8bit: RTL and testbench

- Single-transaction bus driver for an HD44780-compatible 16x2 character LCD in 8-bit parallel mode.
- Accepts one command or character byte per start/done handshake and drives the RS/EN/D[7:0] timing towards the panel.
- Holds off until the controller's execution time has elapsed, then pulses done_tick.
- Sits below a sequencer that walks an init and text ROM (e.g. 0x38, 0x06, 0x0E, 0x01, then ASCII).

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_delay_timer.sv | 24 ++
 rtl/lcd_16x2_8bit.sv | 120 ++++++++++++
 tb/tb_lcd_16x2_8bit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 8-bit bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    EN_HI = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Common HD44780 command bytes used by the init sequencer above us.
  localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] ENTRY_INC       = 8'h06;
  localparam logic [7:0] DISP_ON_CUR     = 8'h0E;
  localparam logic [7:0] CLEAR           = 8'h01;
  localparam logic [7:0] HOME            = 8'h02;

  // Clear/home (0x01..0x03 as commands) need the long execution time.
  function automatic logic is_long(input logic cd, input logic [7:0] d);
    return !cd && (d >= 8'h01) && (d <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; tc_o is high once the count reaches zero.
module lcd_delay_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= RST_VAL;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_16x2_8bit.sv
// HD44780 8-bit write-only bus driver: one byte per start/done handshake.
module lcd_16x2_8bit
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES   = 2_000_000,
  parameter int SETUP_CYCLES     = 4,
  parameter int EN_HIGH_CYCLES   = 50,
  parameter int EXEC_CYCLES      = 2_500,
  parameter int LONG_EXEC_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cd,
  input  logic [7:0] data,
  output logic [7:0] lcd_data,
  output logic       rs,
  output logic       en,
  output logic       done_tick
);

  localparam int M0   = (POWERUP_CYCLES > SETUP_CYCLES) ? POWERUP_CYCLES : SETUP_CYCLES;
  localparam int M1   = (EN_HIGH_CYCLES > EXEC_CYCLES) ? EN_HIGH_CYCLES : EXEC_CYCLES;
  localparam int M2   = (M0 > M1) ? M0 : M1;
  localparam int MAXP = (M2 > LONG_EXEC_CYCLES) ? M2 : LONG_EXEC_CYCLES;
  localparam int CW   = $clog2(MAXP + 1);

  state_t          state_q, state_d;
  logic            long_q, long_d;
  logic            tc, tmr_load;
  logic [CW-1:0]   tmr_val;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            rs_q, rs_d, en_q, en_d, done_q, done_d;

  // Every wait state is timed by one shared counter, reloaded on each state entry.
  lcd_delay_timer #(
    .W       (CW),
    .RST_VAL (CW'(POWERUP_CYCLES - 1))
  ) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tc)
  );

  // State register and latched long-execution flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
    end
  end

  // Next-state logic: each wait state leaves when the timer hits zero.
  always_comb begin
    state_d = state_q;
    long_d  = long_q;
    case (state_q)
      PWRUP: if (tc) state_d = IDLE;
      IDLE:  if (start) begin
               state_d = SETUP;
               long_d  = is_long(cd, data);
             end
      SETUP: if (tc) state_d = EN_HI;
      EN_HI: if (tc) state_d = EXEC;
      EXEC:  if (tc) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = PWRUP;
    endcase
  end

  // Timer reload value for the state being entered (duration minus one).
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      SETUP:   tmr_val = CW'(SETUP_CYCLES - 1);
      EN_HI:   tmr_val = CW'(EN_HIGH_CYCLES - 1);
      EXEC:    tmr_val = long_d ? CW'(LONG_EXEC_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
      DONE:    tmr_val = '0;
      default: tmr_val = CW'(POWERUP_CYCLES - 1);
    endcase
  end

  // Output next values: bus pins latch only on accept, strobes follow the next state.
  always_comb begin
    lcd_data_d = lcd_data_q;
    rs_d       = rs_q;
    if (state_q == IDLE && start) begin
      lcd_data_d = data;
      rs_d       = cd;
    end
    en_d   = (state_d == EN_HI);
    done_d = (state_d == DONE);
  end

  // Registered outputs towards the panel and the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data_q <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      lcd_data_q <= lcd_data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  assign lcd_data  = lcd_data_q;
  assign rs        = rs_q;
  assign en        = en_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_lcd_16x2_8bit.sv
// Directed bench for lcd_16x2_8bit with shortened timing parameters.
module tb_lcd_16x2_8bit;

  localparam int P = 20, S = 2, E = 4, X = 10, L = 40;
  localparam int SHORT = S + E + X;
  localparam int LONG  = S + E + L;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cd = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] lcd_data;
  logic       rs, en, done_tick;

  int n_tests = 0, n_fail = 0, done_total = 0;

  lcd_16x2_8bit #(
    .POWERUP_CYCLES   (P),
    .SETUP_CYCLES     (S),
    .EN_HIGH_CYCLES   (E),
    .EXEC_CYCLES      (X),
    .LONG_EXEC_CYCLES (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cd        (cd),
    .data      (data),
    .lcd_data  (lcd_data),
    .rs        (rs),
    .en        (en),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_tick === 1'b1) done_total++;

  typedef struct {
    logic       cd;
    logic [7:0] d;
    int         lat;
    string      nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT in IDLE; accept happens at the next edge.
  task automatic run_txn(input logic c, input logic [7:0] d, input int lat,
                         input bit tog, input string nm);
    int en_first, en_cnt, done_edge, bad;
    cd = c; data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " lcd_data@accept"}, lcd_data, d);
    chk({nm, " rs@accept"}, rs, c);
    en_first = -1; en_cnt = 0; done_edge = -1; bad = 0;
    for (int k = 1; k <= 200 && done_edge < 0; k++) begin
      @(posedge clk); #1;
      if (lcd_data !== d || rs !== c) bad++;
      if (en === 1'b1) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        if (tog) begin start = 1'b1; data = ~d; cd = ~c; end
      end else if (tog) begin
        start = 1'b0; data = d; cd = c;
      end
      if (done_tick === 1'b1) done_edge = k;
    end
    start = 1'b0;
    chk({nm, " en_rise_edge"}, en_first, S);
    chk({nm, " en_high_cycles"}, en_cnt, E);
    chk({nm, " done_edge"}, done_edge, lat);
    chk({nm, " pins_stable"}, bad, 0);
    @(posedge clk); #1;
    chk({nm, " done_single"}, done_tick, 1'b0);
  endtask

  // Reset (possibly mid-transaction), then hold start from release.
  task automatic pwrup_test(input string nm);
    int acc, en_first, done_edge, early;
    rst = 1'b1; start = 1'b1; cd = 1'b0; data = 8'h38;
    @(posedge clk); #1;
    chk({nm, " rst en"}, en, 1'b0);
    chk({nm, " rst lcd_data"}, lcd_data, 8'h00);
    chk({nm, " rst rs"}, rs, 1'b0);
    chk({nm, " rst done"}, done_tick, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc = -1; en_first = -1; done_edge = -1; early = 0;
    for (int k = 1; k <= 200 && done_edge < 0; k++) begin
      @(posedge clk); #1;
      if (k <= P && (en !== 1'b0 || done_tick !== 1'b0)) early++;
      if (acc < 0 && lcd_data === 8'h38) acc = k;
      if (en_first < 0 && en === 1'b1) en_first = k;
      if (done_tick === 1'b1) begin done_edge = k; start = 1'b0; end
    end
    start = 1'b0;
    chk({nm, " no_activity_in_pwrup"}, early, 0);
    chk({nm, " accept_edge"}, acc, P + 1);
    chk({nm, " en_rise_edge"}, en_first, P + 1 + S);
    chk({nm, " done_edge"}, done_edge, P + 1 + SHORT);
    @(posedge clk); #1;
    chk({nm, " done_single"}, done_tick, 1'b0);
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] seq[16];
    string      txt;
    int         d0, k;

    vecs[0] = '{1'b0, 8'h38, SHORT, "cmd38"};
    vecs[1] = '{1'b1, 8'h48, SHORT, "dat48"};
    vecs[2] = '{1'b0, 8'h01, LONG,  "clear"};
    vecs[3] = '{1'b1, 8'h01, SHORT, "dat01"};
    vecs[4] = '{1'b0, 8'h02, LONG,  "home"};
    vecs[5] = '{1'b0, 8'h03, LONG,  "cmd03"};
    vecs[6] = '{1'b0, 8'h04, SHORT, "cmd04"};
    vecs[7] = '{1'b0, 8'h00, SHORT, "cmd00"};

    pwrup_test("pwrup");

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].cd, vecs[i].d, vecs[i].lat, 1'b0, vecs[i].nm);

    run_txn(1'b0, 8'h0E, SHORT, 1'b1, "toggle");

    // Sequencer-style init + text, back to back with one idle cycle each.
    seq[0] = 8'h38; seq[1] = 8'h06; seq[2] = 8'h0E; seq[3] = 8'h01;
    txt = "HELLO WORLD!";
    for (int i = 0; i < 12; i++) seq[4 + i] = txt[i];
    d0 = done_total;
    for (int i = 0; i < 16; i++)
      run_txn((i < 4) ? 1'b0 : 1'b1, seq[i], (i == 3) ? LONG : SHORT, 1'b0, $sformatf("seq%0d", i));
    chk("seq done_count", done_total - d0, 16);

    // Abort mid-EN_HI with a reset, then the power-up wait must rerun.
    cd = 1'b1; data = 8'h48; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (en !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("abort reached_en", en, 1'b1);
    @(posedge clk); #1;
    pwrup_test("abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
